// File: rtl/prio_enc_scan_pkg.sv
// prio_enc_scan_pkg: shared glyph table and display helpers for the priority encoder scanner
package prio_enc_scan_pkg;

    localparam int SEG_W = 7;

    // Hex glyphs, segment order gfedcba, active-high
    localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Alternate the one-hot digit enable between low and high digit
    function automatic logic [1:0] swap_digit(input logic [1:0] d);
        return {d[0], d[1]};
    endfunction

endpackage

// File: rtl/prio_enc_scan_hex7seg.sv
// hex7seg: combinational 4-bit to 7-segment decode
module hex7seg
    import prio_enc_scan_pkg::*;
(
    input  logic [3:0]       hex,
    output logic [SEG_W-1:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/prio_enc_scan.sv
// prio_enc_scan: fixed/round-robin priority encoder with multiplexed hex display of the grant
module prio_enc_scan
    import prio_enc_scan_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int SCAN_DIV = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data,
    input  logic             mode,
    input  logic             ack,
    input  logic             hold,
    output logic             valid,
    output logic [5:0]       index,
    output logic             none,
    output logic [SEG_W-1:0] segments,
    output logic [1:0]       digit_en
);

    localparam int PW = $clog2(WIDTH);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PTR_MAX = PW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic [WIDTH-1:0] data_q;
    logic [PW-1:0]    ptr;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    start;
    logic             enc_valid;
    logic             lo_hit;
    logic [5:0]       lo_idx;
    logic [5:0]       hi_idx;
    logic [5:0]       enc_idx;
    logic [5:0]       idx_nxt;
    logic             none_nxt;
    logic             wrap;
    logic [1:0]       de_nxt;
    logic [3:0]       nib;
    logic [SEG_W-1:0] glyph;

    // Descending search from start with wrap: the highest set bit at or below start wins,
    // otherwise the highest set bit above start (the first one reached after wrapping)
    always_comb begin
        start     = mode ? ptr : PTR_MAX;
        enc_valid = |data_q;
        lo_hit    = 1'b0;
        lo_idx    = '0;
        hi_idx    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (data_q[i]) begin
                if (i <= int'(start)) begin
                    lo_hit = 1'b1;
                    lo_idx = 6'(i);
                end else begin
                    hi_idx = 6'(i);
                end
            end
        end
        enc_idx = lo_hit ? lo_idx : hi_idx;
    end

    // Values the grant outputs and digit enable take at the next edge, so the
    // registered segments always match the index and digit currently shown
    always_comb begin
        idx_nxt  = hold ? index : enc_idx;
        none_nxt = hold ? none : ~enc_valid;
        wrap     = cnt == CNT_MAX;
        de_nxt   = wrap ? swap_digit(digit_en) : digit_en;
        nib      = de_nxt[1] ? {2'b00, idx_nxt[5:4]} : idx_nxt[3:0];
    end

    hex7seg u_hex7seg (
        .hex (nib),
        .seg (glyph)
    );

    // Input sample, grant registers and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            valid  <= 1'b0;
            index  <= '0;
            none   <= 1'b1;
            ptr    <= PTR_MAX;
        end else begin
            data_q <= data;
            if (!hold) begin
                valid <= enc_valid;
                index <= enc_idx;
                none  <= ~enc_valid;
                if (!mode)
                    ptr <= PTR_MAX;
                else if (ack && valid)
                    ptr <= (index == 6'd0) ? PTR_MAX : PW'(index - 6'd1);
            end
        end
    end

    // Digit scan counter and registered segment drive
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            digit_en <= 2'b01;
            segments <= '0;
        end else begin
            cnt      <= wrap ? '0 : cnt + 1'b1;
            digit_en <= de_nxt;
            segments <= none_nxt ? '0 : glyph;
        end
    end

endmodule
